// File: rtl/port_avalon_bridge_if.sv
// rtl/port_avalon_bridge_if.sv - request port and Avalon-MM master signal bundle for port_avalon_bridge
interface port_avalon_bridge_if #(
    parameter int BURSTCOUNT_WIDTH = 5
);
    logic                        acc_i;
    logic                        we_i;
    logic [31:0]                 adr_i;
    logic [31:0]                 dat_i;
    logic [3:0]                  sel_i;
    logic [3:0]                  buf_width_i;
    logic                        ack_o;
    logic [31:0]                 adr_o;
    logic [31:0]                 dat_o;
    logic [31:0]                 avm_address;
    logic [BURSTCOUNT_WIDTH-1:0] avm_burstcount;
    logic                        avm_read;
    logic                        avm_write;
    logic [31:0]                 avm_writedata;
    logic [3:0]                  avm_byteenable;
    logic                        avm_waitrequest;
    logic [31:0]                 avm_readdata;
    logic                        avm_readdatavalid;

    // Bridge side: serves the port's requests, masters the Avalon bus
    modport slave (
        input  acc_i, we_i, adr_i, dat_i, sel_i, buf_width_i,
        output ack_o, adr_o, dat_o,
        output avm_address, avm_burstcount, avm_read, avm_write,
        output avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    // Environment side: issues requests and answers the Avalon bus
    modport master (
        output acc_i, we_i, adr_i, dat_i, sel_i, buf_width_i,
        input  ack_o, adr_o, dat_o,
        input  avm_address, avm_burstcount, avm_read, avm_write,
        input  avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/port_avalon_bridge.sv
// rtl/port_avalon_bridge.sv - buffered port acc/we/ack requests to Avalon-MM line bursts and single writes
module port_avalon_bridge #(
    parameter int MAX_BUF_WIDTH    = 4,
    parameter int BURSTCOUNT_WIDTH = 5
) (
    input logic                  sdram_clk,
    input logic                  sdram_rst,
    port_avalon_bridge_if.slave  bus
);
    localparam int CNT_W = MAX_BUF_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        RD_CMD,
        RD_DATA,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_len;
    logic [CNT_W-1:0] beat_inc;
    logic [CNT_W-1:0] req_len;
    logic [31:0]      base;
    logic [31:0]      req_base;
    logic [3:0]       req_bw;
    logic             rd_beat;
    logic             last_beat;

    // Clamp the requested line width and derive burst length and line-aligned base
    always_comb begin
        req_bw = bus.buf_width_i;
        if (bus.buf_width_i > 4'(MAX_BUF_WIDTH)) begin
            req_bw = 4'(MAX_BUF_WIDTH);
        end
        req_len  = CNT_W'(1) << req_bw;
        req_base = bus.adr_i & ~((32'd4 << req_bw) - 32'd1);
    end

    // Next-state logic; read beats count in RD_CMD too since data can arrive with acceptance
    always_comb begin
        state_nxt = state;
        beat_inc  = beat_cnt + 1'b1;
        rd_beat   = ((state == RD_CMD) || (state == RD_DATA)) && bus.avm_readdatavalid;
        last_beat = rd_beat && (beat_inc == beat_len);
        case (state)
            IDLE: begin
                if (bus.acc_i) begin
                    if (!bus.we_i) begin
                        state_nxt = RD_CMD;
                    end else if (bus.sel_i != 4'd0) begin
                        state_nxt = WR_CMD;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            WR_CMD: begin
                if (!bus.avm_waitrequest) begin
                    state_nxt = DONE;
                end
            end
            RD_CMD: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end else if (!bus.avm_waitrequest) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Avalon command registers, beat counter and port response registers
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            bus.ack_o          <= 1'b0;
            bus.adr_o          <= 32'd0;
            bus.dat_o          <= 32'd0;
            bus.avm_address    <= 32'd0;
            bus.avm_burstcount <= BURSTCOUNT_WIDTH'(1);
            bus.avm_read       <= 1'b0;
            bus.avm_write      <= 1'b0;
            bus.avm_writedata  <= 32'd0;
            bus.avm_byteenable <= 4'd0;
            beat_cnt           <= '0;
            beat_len           <= '0;
            base               <= 32'd0;
        end else begin
            bus.ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.acc_i) begin
                        if (bus.we_i) begin
                            if (bus.sel_i != 4'd0) begin
                                bus.avm_address    <= {bus.adr_i[31:2], 2'b00};
                                bus.avm_writedata  <= bus.dat_i;
                                bus.avm_byteenable <= bus.sel_i;
                                bus.avm_burstcount <= BURSTCOUNT_WIDTH'(1);
                                bus.avm_write      <= 1'b1;
                            end else begin
                                bus.ack_o <= 1'b1;
                            end
                        end else begin
                            base               <= req_base;
                            beat_len           <= req_len;
                            beat_cnt           <= '0;
                            bus.avm_address    <= req_base;
                            bus.avm_burstcount <= BURSTCOUNT_WIDTH'(req_len);
                            bus.avm_read       <= 1'b1;
                        end
                    end
                end
                WR_CMD: begin
                    if (!bus.avm_waitrequest) begin
                        bus.avm_write <= 1'b0;
                        bus.ack_o     <= 1'b1;
                    end
                end
                RD_CMD, RD_DATA: begin
                    if (!bus.avm_waitrequest || last_beat) begin
                        bus.avm_read <= 1'b0;
                    end
                    if (rd_beat) begin
                        bus.ack_o <= 1'b1;
                        bus.dat_o <= bus.avm_readdata;
                        bus.adr_o <= base | (32'(beat_cnt) << 2);
                        beat_cnt  <= beat_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_port_avalon_bridge.sv
// tb/tb_port_avalon_bridge.sv - randomized self-checking bench for port_avalon_bridge
module tb_port_avalon_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    port_avalon_bridge_if #(.BURSTCOUNT_WIDTH(5)) bus ();

    port_avalon_bridge #(
        .MAX_BUF_WIDTH    (4),
        .BURSTCOUNT_WIDTH (5)
    ) dut (
        .sdram_clk (clk),
        .sdram_rst (rst),
        .bus       (bus)
    );

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int          stall_left = 0;
    bit          coinc      = 1'b0;
    bit          gap3       = 1'b0;
    bit          gap_taken  = 1'b0;
    int          gap_pct    = 0;
    logic [31:0] rd_data [16];
    int          rd_total   = 0;
    int          rd_sent    = 0;
    bit          rd_active  = 1'b0;

    logic [31:0] ack_adr_q [$];
    logic [31:0] ack_dat_q [$];
    int          ack_cyc_q [$];
    int          rdv_cyc_q [$];
    int          wr_cycles  = 0;
    int          wr_accepts = 0;
    int          wr_acc_cyc = 0;
    int          rd_cmds    = 0;
    logic [31:0] rd_cmd_addr = 32'd0;
    logic [31:0] rd_cmd_bc   = 32'd0;
    logic [31:0] exp_wa = 32'd0;
    logic [31:0] exp_wd = 32'd0;
    logic [31:0] exp_wb = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic clear_obs();
        ack_adr_q.delete();
        ack_dat_q.delete();
        ack_cyc_q.delete();
        rdv_cyc_q.delete();
        wr_cycles  = 0;
        wr_accepts = 0;
        wr_acc_cyc = 0;
        rd_cmds    = 0;
    endtask

    task automatic send_beat();
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = rd_data[rd_sent];
        rdv_cyc_q.push_back(cyc);
        rd_sent++;
    endtask

    // One clock: observe DUT at the falling edge, then set Avalon slave responses for the next rise
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (bus.ack_o) begin
            ack_adr_q.push_back(bus.adr_o);
            ack_dat_q.push_back(bus.dat_o);
            ack_cyc_q.push_back(cyc);
        end
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = $urandom();
        bus.avm_waitrequest   = 1'b0;
        if ((bus.avm_write || bus.avm_read) && stall_left > 0) begin
            bus.avm_waitrequest = 1'b1;
            stall_left--;
        end
        if (bus.avm_write) begin
            wr_cycles++;
            check("wr_address", bus.avm_address, exp_wa);
            check("wr_writedata", bus.avm_writedata, exp_wd);
            check("wr_byteenable", 32'(bus.avm_byteenable), exp_wb);
            check("wr_burstcount", 32'(bus.avm_burstcount), 32'd1);
            if (!bus.avm_waitrequest) begin
                wr_accepts++;
                wr_acc_cyc = cyc;
            end
        end
        if (bus.avm_read && !bus.avm_waitrequest) begin
            rd_cmds++;
            rd_cmd_addr = bus.avm_address;
            rd_cmd_bc   = 32'(bus.avm_burstcount);
            rd_active   = 1'b1;
            if (coinc) send_beat();
        end else if (rd_active && rd_sent < rd_total) begin
            if (gap3 && rd_sent == 4 && !gap_taken) begin
                gap_taken = 1'b1;
            end else if ($urandom_range(99) >= gap_pct) begin
                send_beat();
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack_o"}, 32'(bus.ack_o), 32'd0);
        check({tag, "_avm_read"}, 32'(bus.avm_read), 32'd0);
        check({tag, "_avm_write"}, 32'(bus.avm_write), 32'd0);
        check({tag, "_adr_o"}, bus.adr_o, 32'd0);
        check({tag, "_dat_o"}, bus.dat_o, 32'd0);
        check({tag, "_avm_address"}, bus.avm_address, 32'd0);
        check({tag, "_avm_writedata"}, bus.avm_writedata, 32'd0);
        check({tag, "_avm_byteenable"}, 32'(bus.avm_byteenable), 32'd0);
        check({tag, "_avm_burstcount"}, 32'(bus.avm_burstcount), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int stall);
        int start_cyc;
        clear_obs();
        exp_wa     = {adr[31:2], 2'b00};
        exp_wd     = dat;
        exp_wb     = 32'(sel);
        stall_left = stall;
        coinc      = 1'b0;
        rd_active  = 1'b0;
        start_cyc  = cyc;
        bus.acc_i       = 1'b1;
        bus.we_i        = 1'b1;
        bus.adr_i       = adr;
        bus.dat_i       = dat;
        bus.sel_i       = sel;
        bus.buf_width_i = 4'($urandom_range(15));
        cycle();
        bus.adr_i       = $urandom();
        bus.dat_i       = $urandom();
        bus.sel_i       = 4'($urandom_range(15));
        bus.we_i        = 1'($urandom_range(1));
        bus.buf_width_i = 4'($urandom_range(15));
        for (int i = 0; i < 40 && ack_adr_q.size() == 0; i++) cycle();
        cycle();
        bus.acc_i = 1'b0;
        repeat (4) cycle();
        check("wr_ack_count", 32'(ack_adr_q.size()), 32'd1);
        check("wr_accepts", 32'(wr_accepts), (sel != 4'd0) ? 32'd1 : 32'd0);
        check("wr_cmd_cycles", 32'(wr_cycles), (sel != 4'd0) ? 32'(stall + 1) : 32'd0);
        if (ack_cyc_q.size() > 0) begin
            if (sel != 4'd0) check("wr_ack_latency", 32'(ack_cyc_q[0] - wr_acc_cyc), 32'd1);
            else             check("wr_nosel_latency", 32'(ack_cyc_q[0] - start_cyc), 32'd1);
        end
    endtask

    task automatic do_read(input logic [31:0] adr, input int bw, input int stall, input bit c,
                           input bit g3, input int pct, input int reset_at);
        int          ebw;
        int          len;
        int          n_exp;
        logic [31:0] base;
        ebw   = (bw > 4) ? 4 : bw;
        len   = 1 << ebw;
        base  = adr & ~((32'd4 << ebw) - 32'd1);
        n_exp = (reset_at >= 0) ? reset_at : len;
        clear_obs();
        for (int i = 0; i < 16; i++) rd_data[i] = $urandom();
        rd_total   = len;
        rd_sent    = 0;
        rd_active  = 1'b0;
        coinc      = c;
        gap3       = g3;
        gap_taken  = 1'b0;
        gap_pct    = pct;
        stall_left = stall;
        bus.acc_i       = 1'b1;
        bus.we_i        = 1'b0;
        bus.adr_i       = adr;
        bus.dat_i       = $urandom();
        bus.sel_i       = 4'($urandom_range(15));
        bus.buf_width_i = 4'(bw);
        cycle();
        bus.adr_i       = $urandom();
        bus.buf_width_i = 4'($urandom_range(15));
        bus.we_i        = 1'($urandom_range(1));
        for (int i = 0; i < 400 && ack_adr_q.size() < n_exp; i++) cycle();
        if (reset_at >= 0) begin
            #2 rst = 1'b1;
            #1 check_reset_vals("rst_mid");
            repeat (2) cycle();
            bus.acc_i = 1'b0;
            rst = 1'b0;
            repeat (len + 6) cycle();
        end else begin
            cycle();
            bus.acc_i = 1'b0;
            repeat (3) cycle();
        end
        check("rd_cmd_count", 32'(rd_cmds), 32'd1);
        check("rd_cmd_address", rd_cmd_addr, base);
        check("rd_cmd_burstcount", rd_cmd_bc, 32'(len));
        check("rd_ack_count", 32'(ack_adr_q.size()), 32'(n_exp));
        for (int i = 0; i < ack_adr_q.size() && i < len; i++) begin
            check($sformatf("rd_adr_o[%0d]", i), ack_adr_q[i], base + 32'(4 * i));
            check($sformatf("rd_dat_o[%0d]", i), ack_dat_q[i], rd_data[i]);
            if (i < rdv_cyc_q.size())
                check($sformatf("rd_ack_timing[%0d]", i), 32'(ack_cyc_q[i]), 32'(rdv_cyc_q[i] + 1));
        end
        rd_active = 1'b0;
        coinc     = 1'b0;
        gap3      = 1'b0;
        gap_pct   = 0;
    endtask

    initial begin
        bus.acc_i             = 1'b0;
        bus.we_i              = 1'b0;
        bus.adr_i             = 32'd0;
        bus.dat_i             = 32'd0;
        bus.sel_i             = 4'd0;
        bus.buf_width_i       = 4'd0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdata      = 32'd0;
        bus.avm_readdatavalid = 1'b0;
        repeat (2) cycle();
        check_reset_vals("reset");
        rst = 1'b0;
        cycle();

        do_write(32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 0);
        do_write(32'h0000_0208, 32'h1234_5678, 4'h5, 3);
        do_write(32'h0000_0300, 32'hCAFE_F00D, 4'h0, 0);
        do_read(32'h0000_2014, 3, 0, 1'b0, 1'b1, 0, -1);
        do_read(32'h0000_2014, 3, 2, 1'b1, 1'b0, 0, -1);
        do_read(32'h0001_2345, 6, 1, 1'b0, 1'b0, 30, -1);
        do_read(32'h0000_0ABC, 0, 0, 1'b1, 1'b0, 0, -1);
        do_read(32'h0000_1000, 3, 0, 1'b0, 1'b0, 0, 2);
        do_write(32'h0000_0402, 32'h0BAD_F00D, 4'hF, 1);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(1) == 1)
                do_write($urandom(), $urandom(), 4'($urandom_range(15)), $urandom_range(3));
            else
                do_read($urandom(), $urandom_range(7), $urandom_range(3), 1'($urandom_range(1)),
                        1'b0, $urandom_range(50), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
